led_seq_counter: RTL and testbench



---
 rtl/led_seq_pkg.sv | 19 +
 rtl/led_seq_acc.sv | 21 ++
 rtl/led_seq_counter.sv | 60 ++++++
 tb/tb_led_seq_counter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: state encoding and the wrap/saturate adder shared by led_seq_counter.
package led_seq_pkg;
    localparam int STATE_W = 2;
    localparam int MAX_W = 64;
    typedef enum logic [STATE_W-1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
    // Operands arrive zero-extended to MAX_W; w is the real accumulator width, so s[w] is its carry-out.
    function automatic logic [MAX_W-1:0] sat_add(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int w,
        input logic saturate
    );
        logic [MAX_W:0] s;
        logic [MAX_W-1:0] ones;
        s = {1'b0, a} + {1'b0, b};
        ones = {MAX_W{1'b1}} >> (MAX_W - w);
        return (saturate && s[w]) ? ones : s[MAX_W-1:0] & ones;
    endfunction
endpackage

// File: rtl/led_seq_acc.sv
// led_seq_acc: count register with clear-over-add priority and wrap/saturate accumulate.
module led_seq_acc #(
    parameter int CNT_W = 32,
    parameter int LED_W = 8,
    parameter int LED_LSB = 16,
    parameter int SATURATE = 0
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             add,
    input  logic [CNT_W-1:0] step,
    output logic [LED_W-1:0] slice
);
    import led_seq_pkg::*;
    logic [CNT_W-1:0] count;
    always_ff @(posedge CLK)
        if (RST || clear) count <= '0;
        else if (add) count <= CNT_W'(sat_add(MAX_W'(count), MAX_W'(step), CNT_W, SATURATE != 0));
    assign slice = count[LED_LSB +: LED_W];
endmodule

// File: rtl/led_seq_counter.sv
// led_seq_counter: enable-started fixed-length accumulate run driving a slice of the count to LEDs.
// Define LED_HOLD_EN to show a snapshot taken when a run completes instead of the live count.
module led_seq_counter #(
    parameter int CNT_W = 32,
    parameter int VAL_W = 32,
    parameter int LED_W = 8,
    parameter int LED_LSB = 16,
    parameter int RUN_LEN = 4,
    parameter int SATURATE = 0
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic             enable,
    input  logic             clear,
    input  logic [VAL_W-1:0] value,
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic             done
);
    import led_seq_pkg::*;
    localparam int RC_W = $clog2(RUN_LEN + 1);
    state_t state, state_nx;
    logic [RC_W-1:0] rc;
    logic [CNT_W-1:0] step;
    logic [LED_W-1:0] slice;
    always_ff @(posedge CLK)
        if (RST) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge CLK)
        if (RST) begin
            rc <= '0;
            step <= '0;
        end else if (state == IDLE && enable) begin
            rc <= RC_W'(RUN_LEN);
            step <= CNT_W'(value);
        end else if (state == RUN) rc <= rc - RC_W'(1);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (enable) state_nx = ARM;
            ARM:  state_nx = RUN;
            RUN:  if (rc == RC_W'(1)) state_nx = DONE;
            DONE: state_nx = IDLE;
        endcase
    end
    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
    end
    led_seq_acc #(.CNT_W(CNT_W), .LED_W(LED_W), .LED_LSB(LED_LSB), .SATURATE(SATURATE)) u_acc (
        .CLK(CLK), .RST(RST), .clear(clear), .add(state == RUN), .step(step), .slice(slice)
    );
`ifdef LED_HOLD_EN
    always_ff @(posedge CLK)
        if (RST || clear) led <= '0;
        else if (state == DONE) led <= slice;
`else
    assign led = slice;
`endif
endmodule

// File: tb/tb_led_seq_counter.sv
// tb_led_seq_counter: wrap and saturate instances driven in lockstep against a run-timeline model.
module tb_led_seq_counter;
    localparam int RL = 4;
    logic CLK = 0, RST = 1, enable = 0, clear = 0;
    logic [31:0] value = 0;
    logic [7:0] led0, led1;
    logic busy0, busy1, done0, done1;
    logic [41:0] obs [2];
    int nchk = 0, npass = 0;
    // t: cycles since the accepted start (-1 = idle); adds land while t is 1..RL before the edge
    int t = -1;
    logic [31:0] m_step = 0;
    logic [31:0] cnt [2] = '{0, 0};
    logic [7:0] ledh [2] = '{0, 0};

    led_seq_counter #(.SATURATE(0)) dut0 (.CLK(CLK), .RST(RST), .enable(enable), .clear(clear),
        .value(value), .led(led0), .busy(busy0), .done(done0));
    led_seq_counter #(.SATURATE(1)) dut1 (.CLK(CLK), .RST(RST), .enable(enable), .clear(clear),
        .value(value), .led(led1), .busy(busy1), .done(done1));

    assign obs[0] = {led0, busy0, done0, dut0.u_acc.count};
    assign obs[1] = {led1, busy1, done1, dut1.u_acc.count};

    always #5 CLK = ~CLK;

    task automatic model_edge();
        longint unsigned s;
        if (RST) begin
            t = -1;
            m_step = 0;
            cnt = '{0, 0};
            ledh = '{0, 0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (clear) ledh[i] = 0;
                else if (t == RL + 1) ledh[i] = cnt[i][23:16];
                s = longint'(cnt[i]) + longint'(m_step);
                if (clear) cnt[i] = 0;
                else if (t >= 1 && t <= RL) cnt[i] = (i == 1 && s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
            end
            if (t == -1) begin
                if (enable) begin
                    t = 0;
                    m_step = value;
                end
            end else t = (t == RL + 1) ? -1 : t + 1;
        end
    endtask

    function automatic logic [41:0] expv(int i);
        logic [7:0] l;
`ifdef LED_HOLD_EN
        l = ledh[i];
`else
        l = cnt[i][23:16];
`endif
        return {l, t >= 0, t == RL + 1, cnt[i]};
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        RST = 1;
        enable = 1;
        value = 32'h0001_0000;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            nchk++;
            if (obs[i] !== expv(i)) $display("FAIL reset dut%0d got %h exp %h", i, obs[i], expv(i));
            else npass++;
        end
        RST = 0;
        enable = 0;
    endtask

    task automatic test_basic(input logic [31:0] v);
        value = v;
        enable = 1;
        for (int c = 0; c < 9; c++) begin
            tick();
            enable = 0;
            value = $urandom;
            for (int i = 0; i < 2; i++) begin
                nchk++;
                if (obs[i] !== expv(i)) $display("FAIL basic c%0d dut%0d got %h exp %h", c, i, obs[i], expv(i));
                else npass++;
            end
        end
    endtask

    task automatic test_wrap_sat();
        RST = 1;
        tick();
        RST = 0;
        value = 32'hC000_0000;
        enable = 1;
        for (int c = 0; c < 8; c++) begin
            tick();
            enable = 0;
            for (int i = 0; i < 2; i++) begin
                nchk++;
                if (obs[i] !== expv(i)) $display("FAIL wrap_sat c%0d dut%0d got %h exp %h", c, i, obs[i], expv(i));
                else npass++;
            end
        end
        nchk++;
        if (dut1.u_acc.count !== 32'hFFFF_FFFF) $display("FAIL sat_final got %h exp ffffffff", dut1.u_acc.count);
        else npass++;
    endtask

    task automatic test_ignored();
        RST = 1;
        tick();
        RST = 0;
        enable = 1;
        for (int c = 0; c < 15; c++) begin
            value = (c >= 2 && c <= 5) ? 32'h0010_0000 : 32'h0001_0000;
            tick();
            for (int i = 0; i < 2; i++) begin
                nchk++;
                if (obs[i] !== expv(i)) $display("FAIL ignored c%0d dut%0d got %h exp %h", c, i, obs[i], expv(i));
                else npass++;
            end
        end
        enable = 0;
        tick();
        nchk++;
        if (dut0.u_acc.count !== 32'h0008_0000) $display("FAIL ignored_final got %h exp 00080000", dut0.u_acc.count);
        else npass++;
    endtask

    task automatic test_clear();
        RST = 1;
        tick();
        RST = 0;
        value = 32'h0001_0000;
        for (int c = 0; c < 10; c++) begin
            enable = c == 0;
            clear = c == 3 || c == 8;
            tick();
            for (int i = 0; i < 2; i++) begin
                nchk++;
                if (obs[i] !== expv(i)) $display("FAIL clear c%0d dut%0d got %h exp %h", c, i, obs[i], expv(i));
                else npass++;
            end
            if (c == 6) begin
                nchk++;
                if (dut0.u_acc.count !== 32'h0002_0000) $display("FAIL clear_final got %h exp 00020000", dut0.u_acc.count);
                else npass++;
            end
        end
        clear = 0;
    endtask

    task automatic test_reset_mid();
        value = 32'h0003_0000;
        for (int c = 0; c < 14; c++) begin
            enable = c == 0 || c == 6;
            RST = c == 4;
            tick();
            for (int i = 0; i < 2; i++) begin
                nchk++;
                if (obs[i] !== expv(i)) $display("FAIL reset_mid c%0d dut%0d got %h exp %h", c, i, obs[i], expv(i));
                else npass++;
            end
        end
        enable = 0;
        RST = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            RST = $urandom_range(0, 49) == 0;
            enable = $urandom_range(0, 2) == 0;
            clear = $urandom_range(0, 19) == 0;
            case ($urandom_range(0, 3))
                0: value = $urandom;
                1: value = 0;
                default: value = $urandom_range(0, 7) << 14;
            endcase
            tick();
            for (int i = 0; i < 2; i++) begin
                nchk++;
                if (obs[i] !== expv(i)) $display("FAIL random c%0d dut%0d got %h exp %h", c, i, obs[i], expv(i));
                else npass++;
            end
        end
        RST = 0;
        enable = 0;
        clear = 0;
    endtask

    initial begin
        test_reset();
        test_basic(32'h0001_0000);
        test_basic(32'h0000_0000);
        test_basic($urandom);
        test_wrap_sat();
        test_ignored();
        test_clear();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
